afe_l2_addr_gen_type2: RTL

- Multi-channel L2 address generator; successor to the per-channel type1 generator.
- Serves NUM_CHS channels in one block and sits between the ADC register interface and the uDMA RX channel muxing.
- New over type1: 2D strided addressing, half-buffer events, overflow flag, live-config reload in continuous mode.

---
 rtl/afe_addr_gen_pkg.sv | 34 +++
 rtl/afe_l2_addr_gen_ch.sv | 149 ++++++++++++++
 rtl/afe_l2_addr_gen_type2.sv | 81 ++++++++
 3 files changed

// File: rtl/afe_addr_gen_pkg.sv
// Shared types and constants for the multi-channel L2 address generator.
// Contents:
//   AG_* widths      default field widths used by the per-channel shadow config
//   state_e          per-channel FSM state (IDLE, RUN)
//   mode_e           addressing mode (MODE_LINEAR, MODE_STRIDED)
//   shadow_cfg_t     configuration captured at start / reload of a pass
package afe_addr_gen_pkg;

  localparam int unsigned AG_AWIDTH         = 12;
  localparam int unsigned AG_TRANS_SIZE     = 16;
  localparam int unsigned AG_STRIDE_SIZE    = 14;
  localparam int unsigned AG_SUBCH_ID_WIDTH = 2;
  localparam int unsigned AG_ELEM_BYTES     = 4;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef enum logic {
    MODE_LINEAR,
    MODE_STRIDED
  } mode_e;

  // The start address is not kept here: it lives on in row_base / curr_addr,
  // and a reload always takes the live start address.
  typedef struct packed {
    logic [AG_TRANS_SIZE-1:0]  size;
    logic [AG_STRIDE_SIZE-1:0] stride;
    logic [AG_STRIDE_SIZE-1:0] row_len;
    mode_e                     mode;
  } shadow_cfg_t;

endpackage

// File: rtl/afe_l2_addr_gen_ch.sv
// One L2 address-generator channel: IDLE/RUN FSM, shadow config, address and
// byte counters, end / half-buffer events and sticky overflow flag.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   cfg_*                        live configuration and start / clear pulses
//   hit                          transfer with matching sub-id (any state)
//   acc                          accepted transfer (hit while running)
//   curr_addr, wr_ptr,
//   bytes_left                   registered channel status
//   en                           channel running
//   ch_event, half_event         one-cycle event pulses
//   overflow                     sticky: hit while idle
module afe_l2_addr_gen_ch
  import afe_addr_gen_pkg::*;
#(
  parameter int unsigned ELEM_BYTES = AG_ELEM_BYTES
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [AG_AWIDTH-1:0]      cfg_start,
  input  logic [AG_TRANS_SIZE-1:0]  cfg_size,
  input  logic [AG_STRIDE_SIZE-1:0] cfg_stride,
  input  logic [AG_STRIDE_SIZE-1:0] cfg_row_len,
  input  logic                      cfg_mode,
  input  logic                      cfg_continuous,
  input  logic                      cfg_half_evt_en,
  input  logic                      cfg_en,
  input  logic                      cfg_clr,
  input  logic                      hit,
  input  logic                      acc,
  output logic [AG_AWIDTH-1:0]      curr_addr,
  output logic [AG_TRANS_SIZE-1:0]  wr_ptr,
  output logic [AG_TRANS_SIZE-1:0]  bytes_left,
  output logic                      en,
  output logic                      ch_event,
  output logic                      half_event,
  output logic                      overflow
);

  localparam logic [AG_AWIDTH-1:0]      ADDR_STEP = AG_AWIDTH'(ELEM_BYTES);
  localparam logic [AG_TRANS_SIZE-1:0]  CNT_STEP  = AG_TRANS_SIZE'(ELEM_BYTES);
  localparam logic [AG_STRIDE_SIZE-1:0] ROW_STEP  = AG_STRIDE_SIZE'(ELEM_BYTES);

  state_e                    state;
  shadow_cfg_t               shadow;
  logic [AG_AWIDTH-1:0]      row_base;
  logic [AG_STRIDE_SIZE-1:0] row_cnt;
  logic                      half_done;

  logic                      advance;
  logic                      last;
  logic                      strided;
  logic                      row_done;
  logic                      half_hit;
  logic                      do_load;
  logic [AG_TRANS_SIZE-1:0]  wr_ptr_nxt;
  logic [AG_STRIDE_SIZE-1:0] row_cnt_nxt;
  logic [AG_AWIDTH-1:0]      next_base;

  assign en          = (state == RUN);
  assign advance     = en && acc;
  assign last        = (bytes_left <= CNT_STEP);
  assign wr_ptr_nxt  = wr_ptr + CNT_STEP;
  assign row_cnt_nxt = row_cnt + ROW_STEP;
  assign strided     = (shadow.mode == MODE_STRIDED) && (shadow.row_len != '0);
  assign row_done    = (row_cnt_nxt >= shadow.row_len);
  // Stride wider than the address is truncated: address math wraps silently.
  assign next_base   = row_base + AG_AWIDTH'(shadow.stride);
  assign half_hit    = cfg_half_evt_en && !half_done && (wr_ptr_nxt >= (shadow.size >> 1));
  // Same capture for a fresh start and for a continuous-mode reload.
  assign do_load     = (!en && cfg_en && (cfg_size != '0)) ||
                       (advance && last && cfg_continuous);

  // NOTE: every register in this block uses <= so that all updates see the
  // pre-edge values; later assignments in the block override earlier ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      shadow     <= '0;
      row_base   <= '0;
      row_cnt    <= '0;
      half_done  <= 1'b0;
      curr_addr  <= '0;
      wr_ptr     <= '0;
      bytes_left <= '0;
      ch_event   <= 1'b0;
      half_event <= 1'b0;
      overflow   <= 1'b0;
    end else if (cfg_clr) begin
      // Clear beats start, accept and reload, and suppresses any event.
      state      <= IDLE;
      shadow     <= '0;
      row_base   <= '0;
      row_cnt    <= '0;
      half_done  <= 1'b0;
      curr_addr  <= '0;
      wr_ptr     <= '0;
      bytes_left <= '0;
      ch_event   <= 1'b0;
      half_event <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ch_event   <= 1'b0;
      half_event <= 1'b0;

      if (hit && !en) overflow <= 1'b1;

      if (advance) begin
        if (half_hit) begin
          half_event <= 1'b1;
          half_done  <= 1'b1;
        end
        if (last) begin
          // Final (possibly partial) element: address stays on it.
          ch_event <= 1'b1;
          if (!cfg_continuous) begin
            state      <= IDLE;
            wr_ptr     <= shadow.size;
            bytes_left <= '0;
          end
        end else begin
          wr_ptr     <= wr_ptr_nxt;
          bytes_left <= bytes_left - CNT_STEP;
          if (strided && row_done) begin
            row_base  <= next_base;
            curr_addr <= next_base;
            row_cnt   <= '0;
          end else begin
            if (strided) row_cnt <= row_cnt_nxt;
            curr_addr <= curr_addr + ADDR_STEP;
          end
        end
      end

      if (do_load) begin
        state      <= RUN;
        shadow     <= '{size: cfg_size, stride: cfg_stride, row_len: cfg_row_len,
                        mode: mode_e'(cfg_mode)};
        curr_addr  <= cfg_start;
        row_base   <= cfg_start;
        row_cnt    <= '0;
        wr_ptr     <= '0;
        bytes_left <= cfg_size;
        half_done  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/afe_l2_addr_gen_type2.sv
// Multi-channel L2 address generator between the ADC register interface and
// the uDMA RX channel mux. Decodes accepted transfers per channel and
// instantiates one independent afe_l2_addr_gen_ch per channel.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   cfg_*_i                per-channel configuration, start and clear pulses
//   udma_subch_id_i        sub-channel id of the sample being consumed
//   udma_vtransfer_i       per-channel valid transfer
//   curr_addr_o, wr_ptr_o,
//   bytes_left_o, en_o     per-channel registered status
//   ch_event_o,
//   half_event_o           per-channel one-cycle event pulses
//   overflow_o             per-channel sticky overflow flag
module afe_l2_addr_gen_type2
  import afe_addr_gen_pkg::*;
#(
  parameter int unsigned AWIDTH         = AG_AWIDTH,
  parameter int unsigned TRANS_SIZE     = AG_TRANS_SIZE,
  parameter int unsigned STRIDE_SIZE    = AG_STRIDE_SIZE,
  parameter int unsigned NUM_CHS        = 8,
  parameter int unsigned SUBCH_ID_WIDTH = AG_SUBCH_ID_WIDTH,
  parameter int unsigned ELEM_BYTES     = AG_ELEM_BYTES
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NUM_CHS-1:0][AWIDTH-1:0]           cfg_startaddr_i,
  input  logic [NUM_CHS-1:0][TRANS_SIZE-1:0]       cfg_size_i,
  input  logic [NUM_CHS-1:0][STRIDE_SIZE-1:0]      cfg_stride_i,
  input  logic [NUM_CHS-1:0][STRIDE_SIZE-1:0]      cfg_row_len_i,
  input  logic [NUM_CHS-1:0]                       cfg_mode_i,
  input  logic [NUM_CHS-1:0][SUBCH_ID_WIDTH-1:0]   cfg_subch_id_i,
  input  logic [NUM_CHS-1:0]                       cfg_continuous_i,
  input  logic [NUM_CHS-1:0]                       cfg_half_evt_en_i,
  input  logic [NUM_CHS-1:0]                       cfg_en_i,
  input  logic [NUM_CHS-1:0]                       cfg_clr_i,
  input  logic [SUBCH_ID_WIDTH-1:0]                udma_subch_id_i,
  input  logic [NUM_CHS-1:0]                       udma_vtransfer_i,
  output logic [NUM_CHS-1:0][AWIDTH-1:0]           curr_addr_o,
  output logic [NUM_CHS-1:0][TRANS_SIZE-1:0]       wr_ptr_o,
  output logic [NUM_CHS-1:0][TRANS_SIZE-1:0]       bytes_left_o,
  output logic [NUM_CHS-1:0]                       en_o,
  output logic [NUM_CHS-1:0]                       ch_event_o,
  output logic [NUM_CHS-1:0]                       half_event_o,
  output logic [NUM_CHS-1:0]                       overflow_o
);

  logic [NUM_CHS-1:0] hit;
  logic [NUM_CHS-1:0] acc;

  for (genvar i = 0; i < NUM_CHS; i++) begin : g_ch
    // hit also drives the idle-overflow detection, acc only the advance.
    assign hit[i] = udma_vtransfer_i[i] && (udma_subch_id_i == cfg_subch_id_i[i]);
    assign acc[i] = en_o[i] && hit[i];

    afe_l2_addr_gen_ch #(
      .ELEM_BYTES (ELEM_BYTES)
    ) u_ch (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .cfg_start       (cfg_startaddr_i[i]),
      .cfg_size        (cfg_size_i[i]),
      .cfg_stride      (cfg_stride_i[i]),
      .cfg_row_len     (cfg_row_len_i[i]),
      .cfg_mode        (cfg_mode_i[i]),
      .cfg_continuous  (cfg_continuous_i[i]),
      .cfg_half_evt_en (cfg_half_evt_en_i[i]),
      .cfg_en          (cfg_en_i[i]),
      .cfg_clr         (cfg_clr_i[i]),
      .hit             (hit[i]),
      .acc             (acc[i]),
      .curr_addr       (curr_addr_o[i]),
      .wr_ptr          (wr_ptr_o[i]),
      .bytes_left      (bytes_left_o[i]),
      .en              (en_o[i]),
      .ch_event        (ch_event_o[i]),
      .half_event      (half_event_o[i]),
      .overflow        (overflow_o[i])
    );
  end

endmodule
